// File: rtl/dual_port_ram.sv
// True dual-port synchronous RAM: two read/write ports share one array on a single clock.
// Define DUAL_COLLISION_DETECT_EN to add a registered same-address `collision` flag output.
module dual_port_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_a,
  input  logic              we_b,
  input  logic [DATA_W-1:0] data_a,
  input  logic [DATA_W-1:0] data_b,
  input  logic [ADDR_W-1:0] add_a,
  input  logic [ADDR_W-1:0] add_b,
  output logic [DATA_W-1:0] read_a,
  output logic [DATA_W-1:0] read_b
`ifdef DUAL_COLLISION_DETECT_EN
  ,
  output logic              collision
`endif
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic w_inRangeA;
  logic w_inRangeB;
  logic w_sameAddr;
  logic w_writeA;
  logic w_writeB;

  assign w_inRangeA = (32'(add_a) < 32'(DEPTH));
  assign w_inRangeB = (32'(add_b) < 32'(DEPTH));
  assign w_sameAddr = (add_a == add_b);
  assign w_writeA   = we_a && w_inRangeA;
  // Port A wins a same-address double write, so B's write is suppressed.
  assign w_writeB   = we_b && w_inRangeB && !(we_a && w_sameAddr);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_writeB) begin
        r_mem[add_b] <= data_b;
      end
      if (w_writeA) begin
        r_mem[add_a] <= data_a;
      end
    end
  end

  // Reads sample the array before this edge's writes land, giving old data across ports.
  always_ff @(posedge clk) begin
    if (rst) begin
      read_a <= '0;
    end else if (!w_inRangeA) begin
      read_a <= '0;
    end else if (we_a) begin
      read_a <= data_a;
    end else begin
      read_a <= r_mem[add_a];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      read_b <= '0;
    end else if (!w_inRangeB) begin
      read_b <= '0;
    end else if (we_b) begin
      read_b <= (we_a && w_sameAddr) ? data_a : data_b;
    end else begin
      read_b <= r_mem[add_b];
    end
  end

`ifdef DUAL_COLLISION_DETECT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      collision <= 1'b0;
    end else begin
      collision <= w_sameAddr && (we_a || we_b);
    end
  end
`endif

endmodule

// File: tb/tb_dual_port_ram.sv
// Directed self-checking bench for dual_port_ram; covers reset, fills, collisions and mid-run reset.
// Collision-flag checks are compiled in when DUAL_COLLISION_DETECT_EN is defined.
module tb_dual_port_ram;

  logic       clk;
  logic       rst;
  logic       we_a;
  logic       we_b;
  logic [7:0] data_a;
  logic [7:0] data_b;
  logic [7:0] add_a;
  logic [7:0] add_b;
  logic [7:0] read_a;
  logic [7:0] read_b;
`ifdef DUAL_COLLISION_DETECT_EN
  logic       collision;
`endif

  int checks;
  int failures;

  dual_port_ram #(.DATA_W(8), .ADDR_W(8), .DEPTH(256)) dut (
    .clk    (clk),
    .rst    (rst),
    .we_a   (we_a),
    .we_b   (we_b),
    .data_a (data_a),
    .data_b (data_b),
    .add_a  (add_a),
    .add_b  (add_b),
    .read_a (read_a),
    .read_b (read_b)
`ifdef DUAL_COLLISION_DETECT_EN
    ,
    .collision (collision)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one cycle of inputs, then returns 1 time unit after the capturing edge.
  task automatic applyStimulus(input logic iRst,
                               input logic iWeA, input logic [7:0] iAddA, input logic [7:0] iDataA,
                               input logic iWeB, input logic [7:0] iAddB, input logic [7:0] iDataB);
    rst    = iRst;
    we_a   = iWeA;
    add_a  = iAddA;
    data_a = iDataA;
    we_b   = iWeB;
    add_b  = iAddB;
    data_b = iDataB;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%02h expected=0x%02h", tag, observed, expected);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst = 1'b0; we_a = 1'b0; we_b = 1'b0;
    data_a = 8'h00; data_b = 8'h00; add_a = 8'h00; add_b = 8'h00;
    #2;

    // Reset with a write presented: the write must be ignored.
    applyStimulus(1'b1, 1'b1, 8'd0, 8'hFF, 1'b1, 8'd1, 8'hEE);
    checkOutput("reset_read_a", read_a, 8'h00);
    checkOutput("reset_read_b", read_b, 8'h00);
`ifdef DUAL_COLLISION_DETECT_EN
    checkOutput("reset_collision", {7'd0, collision}, 8'h00);
`endif

    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 1'b0, 8'(i), 8'h00, 1'b0, 8'(19 - i), 8'h00);
      checkOutput($sformatf("post_reset_a[%0d]", i), read_a, 8'h00);
      checkOutput($sformatf("post_reset_b[%0d]", 19 - i), read_b, 8'h00);
    end

    // Port A fill with write-first echo on read_a.
    for (int i = 0; i < 15; i++) begin
      applyStimulus(1'b0, 1'b1, 8'(i), 8'(2 * i), 1'b0, 8'd200, 8'h00);
      checkOutput($sformatf("fillA_echo[%0d]", i), read_a, 8'(2 * i));
    end
    for (int i = 0; i < 15; i++) begin
      applyStimulus(1'b0, 1'b0, 8'd0, 8'h00, 1'b0, 8'(i), 8'h00);
      checkOutput($sformatf("fillA_readB[%0d]", i), read_b, 8'(2 * i));
    end

    // Port B fill overwrites 10..14 and extends to 19.
    for (int j = 10; j < 20; j++) begin
      applyStimulus(1'b0, 1'b0, 8'd100, 8'h00, 1'b1, 8'(j), 8'(3 * j));
      checkOutput($sformatf("fillB_echo[%0d]", j), read_b, 8'(3 * j));
    end
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 1'b0, 8'(i), 8'h00, 1'b0, 8'd100, 8'h00);
      checkOutput($sformatf("fillB_readA[%0d]", i), read_a, (i < 10) ? 8'(2 * i) : 8'(3 * i));
    end

    // Both ports write address 5: A wins everywhere.
    applyStimulus(1'b0, 1'b1, 8'd5, 8'hAA, 1'b1, 8'd5, 8'h55);
    checkOutput("coll_write_read_a", read_a, 8'hAA);
    checkOutput("coll_write_read_b", read_b, 8'hAA);
`ifdef DUAL_COLLISION_DETECT_EN
    checkOutput("coll_flag_set", {7'd0, collision}, 8'h01);
`endif
    applyStimulus(1'b0, 1'b0, 8'd5, 8'h00, 1'b0, 8'd5, 8'h00);
    checkOutput("coll_mem_via_a", read_a, 8'hAA);
    checkOutput("coll_mem_via_b", read_b, 8'hAA);
`ifdef DUAL_COLLISION_DETECT_EN
    checkOutput("coll_flag_clear", {7'd0, collision}, 8'h00);
`endif

    // A writes while B reads the same address: B sees old data.
    applyStimulus(1'b0, 1'b1, 8'd3, 8'h77, 1'b0, 8'd3, 8'h00);
    checkOutput("rdw_a_echo", read_a, 8'h77);
    checkOutput("rdw_b_old", read_b, 8'h06);
`ifdef DUAL_COLLISION_DETECT_EN
    checkOutput("rdw_flag", {7'd0, collision}, 8'h01);
`endif
    applyStimulus(1'b0, 1'b0, 8'd0, 8'h00, 1'b0, 8'd3, 8'h00);
    checkOutput("rdw_b_new", read_b, 8'h77);

    // B writes while A reads the same address: A sees old data.
    applyStimulus(1'b0, 1'b0, 8'd7, 8'h00, 1'b1, 8'd7, 8'h33);
    checkOutput("rdw_a_old", read_a, 8'h0E);
    checkOutput("rdw_b_echo", read_b, 8'h33);
    applyStimulus(1'b0, 1'b0, 8'd7, 8'h00, 1'b0, 8'd9, 8'h00);
    checkOutput("rdw_a_new", read_a, 8'h33);
    checkOutput("indep_b_read", read_b, 8'h12);

    // Independent writes on different addresses in one edge.
    applyStimulus(1'b0, 1'b1, 8'd30, 8'hC3, 1'b1, 8'd31, 8'h3C);
`ifdef DUAL_COLLISION_DETECT_EN
    checkOutput("indep_flag", {7'd0, collision}, 8'h00);
`endif
    applyStimulus(1'b0, 1'b0, 8'd31, 8'h00, 1'b0, 8'd30, 8'h00);
    checkOutput("indep_a_sees_b", read_a, 8'h3C);
    checkOutput("indep_b_sees_a", read_b, 8'hC3);

    // Both read the same address.
    applyStimulus(1'b0, 1'b0, 8'd12, 8'h00, 1'b0, 8'd12, 8'h00);
    checkOutput("both_read_a", read_a, 8'd36);
    checkOutput("both_read_b", read_b, 8'd36);

    // Read data holds with no new edge-sampled change of address.
    applyStimulus(1'b0, 1'b0, 8'd12, 8'h00, 1'b0, 8'd12, 8'h00);
    checkOutput("hold_read_a", read_a, 8'd36);

    // Write burst interrupted by reset.
    applyStimulus(1'b0, 1'b1, 8'd20, 8'h91, 1'b1, 8'd40, 8'h92);
    applyStimulus(1'b0, 1'b1, 8'd21, 8'h93, 1'b1, 8'd41, 8'h94);
    applyStimulus(1'b1, 1'b1, 8'd22, 8'h95, 1'b1, 8'd42, 8'h96);
    checkOutput("midrst_read_a", read_a, 8'h00);
    checkOutput("midrst_read_b", read_b, 8'h00);
    for (int i = 0; i < 45; i += 3) begin
      applyStimulus(1'b0, 1'b0, 8'(i), 8'h00, 1'b0, 8'(i + 1), 8'h00);
      checkOutput($sformatf("midrst_a[%0d]", i), read_a, 8'h00);
      checkOutput($sformatf("midrst_b[%0d]", i + 1), read_b, 8'h00);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
